// File: rtl/itch_msg_serializer.sv
// ITCH transmit framer: descriptor + payload stream -> type, len_hi, len_lo, payload on one byte lane.
// Define ITCH_TX_CHECKSUM_EN to append an XOR checksum byte (carrying eof) to every message.
module itch_msg_serializer #(
  parameter int MAX_LEN    = 1024,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [7:0]  hdr_type,
  input  logic [15:0] hdr_len,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [7:0]  pl_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        len_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
`ifdef ITCH_TX_CHECKSUM_EN
    CKSUM,
`endif
    GAP
  } state_e;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);
  localparam logic [7:0]  GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam state_e      EOF_NEXT  = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  gap_q, gap_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_sof_q, tx_sof_d;
  logic        tx_eof_q, tx_eof_d;
  logic        len_err_q, len_err_d;

  logic        load_en;
  logic        emit;
  logic [7:0]  emit_data;
  logic        emit_sof;
  logic        emit_eof;

`ifdef ITCH_TX_CHECKSUM_EN
  logic [7:0]  cks_q, cks_d;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    load_en   = !tx_valid_q || tx_ready;
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    len_err_d = 1'b0;
    hdr_ready = 1'b0;
    pl_ready  = 1'b0;
    emit      = 1'b0;
    emit_data = 8'h00;
    emit_sof  = 1'b0;
    emit_eof  = 1'b0;

    case (state_q)
      IDLE: begin
        hdr_ready = load_en && !rst;
        if (hdr_valid && hdr_ready) begin
          if ({1'b0, hdr_len} > MAX_LEN_W) begin
            len_err_d = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_data = hdr_type;
            emit_sof  = 1'b1;
            len_d     = hdr_len;
            state_d   = LEN_HI;
          end
        end
      end

      LEN_HI: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_data = len_q[15:8];
          state_d   = LEN_LO;
        end
      end

      LEN_LO: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_data = len_q[7:0];
          rem_d     = len_q;
          if (len_q == 16'd0) begin
`ifdef ITCH_TX_CHECKSUM_EN
            state_d  = CKSUM;
`else
            emit_eof = 1'b1;
            state_d  = EOF_NEXT;
`endif
          end else begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        pl_ready = load_en;
        if (pl_valid && load_en) begin
          emit      = 1'b1;
          emit_data = pl_data;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef ITCH_TX_CHECKSUM_EN
            state_d  = CKSUM;
`else
            emit_eof = 1'b1;
            state_d  = EOF_NEXT;
`endif
          end
        end
      end

`ifdef ITCH_TX_CHECKSUM_EN
      CKSUM: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_data = cks_q;
          emit_eof  = 1'b1;
          state_d   = EOF_NEXT;
        end
      end
`endif

      GAP: begin
        // The first GAP cycle still holds the eof byte; counting starts only once it drains.
        if (load_en) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = 8'd0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    tx_valid_d = load_en ? emit : tx_valid_q;
    tx_data_d  = emit ? emit_data : tx_data_q;
    tx_sof_d   = emit ? emit_sof  : tx_sof_q;
    tx_eof_d   = emit ? emit_eof  : tx_eof_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      rem_q      <= 16'd0;
      gap_q      <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      len_err_q  <= len_err_d;
    end
  end

`ifdef ITCH_TX_CHECKSUM_EN
  // The type byte restarts the running XOR; every later emitted byte folds in.
  always_comb begin
    cks_d = cks_q;
    if (emit) cks_d = emit_sof ? emit_data : (cks_q ^ emit_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cks_q <= 8'h00;
    else     cks_q <= cks_d;
  end
`endif

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_sof   = tx_sof_q;
  assign tx_eof   = tx_eof_q;
  assign len_err  = len_err_q;
  assign busy     = (state_q != IDLE) || tx_valid_q;

endmodule

// File: doc/itch_msg_serializer.md
Name: itch_msg_serializer

Overview:
Transmit-side counterpart of the speculative ITCH header parser. Takes a message descriptor (type, payload length) plus a payload byte stream and emits one serial byte stream on the wire. Wire format is byte0 = msg_type, byte1 = len[15:8], byte2 = len[7:0], then exactly len payload bytes. Sits between the order-gateway message builder and the byte-lane link TX, with full valid/ready backpressure on every side.

Parameters:
MAX_LEN, 1024, largest accepted payload length in bytes; a header with a larger length is rejected.
GAP_CYCLES, 0, idle cycles forced between the last byte of one message and the first byte of the next (0..255).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
hdr_valid  in  1  descriptor valid
hdr_ready  out  1  descriptor accept
hdr_type  in  8  message type
hdr_len  in  16  payload byte count (0 allowed)
pl_valid  in  1  payload byte valid
pl_ready  out  1  payload byte accept
pl_data  in  8  payload byte
tx_valid  out  1  output byte valid
tx_ready  in  1  downstream accept
tx_data  out  8  output byte
tx_sof  out  1  tx_data is byte0 of a message
tx_eof  out  1  tx_data is last byte of a message
len_err  out  1  one-cycle pulse: descriptor rejected (hdr_len > MAX_LEN)
busy  out  1  state != IDLE or tx_valid high

Behaviour:
- Reset (async assert): state=IDLE, tx_valid=0, tx_data=0, tx_sof=0, tx_eof=0, len_err=0, hdr_ready=0 during rst, counters=0. Any message in flight is abandoned; no partial byte is held after release.
- Output register: tx_data/tx_sof/tx_eof are registered. Once tx_valid=1 they stay stable until tx_valid&tx_ready. New byte loads when load_en = !tx_valid | tx_ready.
- States: IDLE, LEN_HI, LEN_LO, PAYLOAD, CKSUM (only with the optional feature), GAP.
- IDLE: hdr_ready = load_en. On hdr_valid&hdr_ready:
  - hdr_len > MAX_LEN: len_err pulses next cycle, nothing is emitted, stay IDLE.
  - Otherwise latch type/len, load tx_data=hdr_type with tx_sof=1, go to LEN_HI. First byte is valid the cycle after acceptance (latency 1).
- LEN_HI: on load_en emit len[15:8] and go to LEN_LO.
- LEN_LO: on load_en emit len[7:0]. If len==0, tx_eof=1 on this byte and go to GAP (or IDLE if GAP_CYCLES==0). Otherwise remaining=len and go to PAYLOAD.
- PAYLOAD: pl_ready = load_en. Each pl_valid&pl_ready emits pl_data and decrements remaining (16-bit). tx_eof=1 on the byte where remaining==1. Then go to GAP/IDLE. pl_ready=0 in every other state, and bytes beyond len are never consumed.
- GAP: counts GAP_CYCLES cycles starting once the eof byte has been accepted (tx_valid&tx_ready), then goes to IDLE.
- Back-to-back: with GAP_CYCLES=0 and tx_ready=1, the next descriptor is accepted in the same cycle the eof byte is accepted. Sustained rate is 1 byte/cycle.
- No bubbles are inserted by the block itself. A gap on pl_valid leaves tx_valid=0 only after the held byte drains.
- hdr_valid while not IDLE: ignored (hdr_ready=0); the descriptor must be held by the source.
- tx_ready=0 mid-message: all state freezes and the held byte is unchanged.

Optional Feature:
ITCH_TX_CHECKSUM_EN:
- Defined: a running 8-bit XOR covers every emitted byte of the message (type, both len bytes, payload). After the last payload byte (or after LEN_LO when len==0), state CKSUM emits the XOR as one extra byte carrying tx_eof=1. The payload's last byte then has tx_eof=0. Wire length is 3+len+1.
- Undefined: no CKSUM state, no accumulator, wire length is 3+len.

Test Plan:
- Basic: hdr type=0x41 len=3, payload A1 A2 A3, tx_ready=1 -> tx bytes 41 00 03 A1 A2 A3 on consecutive cycles, sof on 41, eof on A3.
- Zero length: type=0x53 len=0 -> bytes 53 00 00, eof on the last 00; pl_ready never asserted.
- Backpressure: len=2, tx_ready toggles 1,0,0,1… -> tx_data stable while stalled; exact sequence preserved; pl_ready low while stalled.
- Reject: MAX_LEN=1024, hdr_len=1025 -> len_err one pulse, tx_valid stays 0, next valid header sent normally.
- Gap/back-to-back: GAP_CYCLES=2, two len=1 msgs -> exactly 2 idle cycles between eof and the next sof. With GAP_CYCLES=0 -> no idle cycle.
- Reset mid-payload plus checksum: assert rst after byte 4 of len=4 -> tx_valid=0 immediately and IDLE. With ITCH_TX_CHECKSUM_EN, msg 41 00 02 10 20 -> trailing byte 0x73 with eof.
